// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and defaults for the data-memory arbiter
package dmem_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-input arbiter with registered last-winner pointer
module arb_rr2
  import dmem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       prio_mode,
  input  logic       advance,
  output logic       winner,
  output logic       valid
);

  // req[0] is the CPU, req[1] the host; starts as if the host won last so the CPU wins first
  logic last_winner;

  // Pick a winner: a lone requester wins, contention goes to the CPU or to whoever did not win last
  always_comb begin
    valid  = |req;
    winner = REQ_CPU;
    case (req)
      2'b10:   winner = REQ_HOST;
      2'b11:   winner = (prio_mode || (last_winner == REQ_HOST)) ? REQ_CPU : REQ_HOST;
      default: winner = REQ_CPU;
    endcase
  end

  // Record the winner of every grant, contended or not
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_winner <= REQ_HOST;
    else if (advance)
      last_winner <= winner;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - req/done arbiter sharing one synchronous-read data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PRIO_MODE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state, state_nxt;
  logic              win_id, win_valid, grant;
  logic              owner, op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

  // Grants only happen from IDLE; held off while reset is asserted so every output reads 0
  assign grant = (state == IDLE) && win_valid && !reset;

  arb_rr2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       ({host_req, cpu_req}),
    .prio_mode (PRIO_MODE != 0),
    .advance   (grant),
    .winner    (win_id),
    .valid     (win_valid)
  );

  // State register; reset aborts any access immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state: IDLE -> ACCESS on a request, then one cycle each in ACCESS and RESP
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's operands at grant so later changes on its inputs are ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner    <= REQ_CPU;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else if (grant) begin
      owner    <= win_id;
      op_we    <= (win_id == REQ_HOST) ? host_we    : cpu_we;
      op_addr  <= (win_id == REQ_HOST) ? host_addr  : cpu_addr;
      op_wdata <= (win_id == REQ_HOST) ? host_wdata : cpu_wdata;
    end
  end

  // Keep each requester's last read value; writes leave it untouched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else if ((state == RESP) && !op_we) begin
      if (owner == REQ_CPU)
        cpu_rdata_q  <= mem_rdata;
      else
        host_rdata_q <= mem_rdata;
    end
  end

  // Outputs: grant pulse in IDLE, memory strobe in ACCESS, done and read bypass in RESP
  always_comb begin
    cpu_gnt    = grant && (win_id == REQ_CPU);
    host_gnt   = grant && (win_id == REQ_HOST);
    mem_en     = (state == ACCESS);
    mem_we     = (state == ACCESS) && op_we;
    mem_addr   = op_addr;
    mem_wdata  = op_wdata;
    cpu_done   = (state == RESP) && (owner == REQ_CPU);
    host_done  = (state == RESP) && (owner == REQ_HOST);
    busy       = (state != IDLE);
    cpu_rdata  = cpu_rdata_q;
    host_rdata = host_rdata_q;
    if ((state == RESP) && !op_we) begin
      if (owner == REQ_CPU)
        cpu_rdata  = mem_rdata;
      else
        host_rdata = mem_rdata;
    end
  end

endmodule
